// File: rtl/pa_dtu_dbginfo_dump_if.sv
// pa_dtu_dbginfo_dump_if
//   Output word stream from the debug-info dump sequencer to the
//   debug-module side.
//   dump_valid : word on dump_data is valid (producer -> consumer)
//   dump_data  : DATA_WIDTH-bit snapshot word (producer -> consumer)
//   dump_ready : consumer can take the word (consumer -> producer)
//   modport master : the dump sequencer (producer)
//   modport slave  : the debug-module side (consumer)
interface pa_dtu_dbginfo_dump_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  dump_valid;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_ready;

    modport master (
        output dump_valid,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        output dump_ready
    );
endinterface

// File: rtl/pa_dtu_dbginfo_dump.sv
// pa_dtu_dbginfo_dump
//   Debug-info dump sequencer. On dump_req it walks the snapshot read
//   pointer back to word 0, then reads all NUM_WORDS words, checks each
//   word's pointer tag against the expected index and streams the words
//   out over a valid/ready interface. The final read strobe wraps the
//   snapshot pointer back to 0.
// Ports
//   dbginfo_clk       : clock
//   cpurst_b          : asynchronous active-low reset
//   dump_req          : start-dump pulse, honoured only when idle
//   dump_abort        : abort, highest priority
//   dbgfifo_regs_data : current snapshot word, tag in [PTR_WIDTH-1:0]
//   dbg_info_record   : snapshot capture pulse (stale-snapshot detect)
//   dump_rd_strobe    : advances the snapshot pointer at the next edge
//   dump_busy         : sequencer not idle
//   dump_done         : one-cycle completion pulse
//   dump_err          : sticky error, cleared by the next accepted dump_req
//   dump_err_code     : 00 none, 01 tag mismatch, 10 align timeout,
//                       11 stale snapshot
//   dump_if (master)  : dump_valid / dump_data out, dump_ready in
module pa_dtu_dbginfo_dump #(
    parameter int unsigned NUM_WORDS  = 11,
    parameter int unsigned PTR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  dbginfo_clk,
    input  logic                  cpurst_b,
    input  logic                  dump_req,
    input  logic                  dump_abort,
    input  logic [DATA_WIDTH-1:0] dbgfifo_regs_data,
    input  logic                  dbg_info_record,
    output logic                  dump_rd_strobe,
    output logic                  dump_busy,
    output logic                  dump_done,
    output logic                  dump_err,
    output logic [1:0]            dump_err_code,
    pa_dtu_dbginfo_dump_if.master dump_if
);

    localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_WORDS - 1);
    localparam logic [PTR_WIDTH:0]   ACNT_MAX = (PTR_WIDTH + 1)'(NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        CAPTURE,
        PUSH,
        DONE
    } state_e;

    state_e                state;
    logic [PTR_WIDTH-1:0]  idx;
    logic [PTR_WIDTH:0]    acnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [1:0]            code_q;

    logic [PTR_WIDTH-1:0]  tag;
    logic                  align_step;
    logic                  accept;
    logic                  stale;

    always_comb begin
        tag        = dbgfifo_regs_data[PTR_WIDTH-1:0];
        align_step = (state == ALIGN) && (tag != '0) && (acnt != ACNT_MAX);
        accept     = (state == PUSH) && dump_if.dump_ready;
        // The strobe is suppressed in an abort cycle so the snapshot
        // pointer is left exactly where the aborted dump stopped.
        dump_rd_strobe = !dump_abort && (align_step || accept);
        stale = dbg_info_record &&
                ((state == ALIGN) || (state == CAPTURE) || (state == PUSH));
    end

    always_ff @(posedge dbginfo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state   <= IDLE;
            idx     <= '0;
            acnt    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            done_q <= 1'b0;
            if (dump_abort) begin
                // Error state survives an abort; only the sequencing stops.
                state   <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                // First error wins. A same-cycle tag mismatch or timeout
                // below overrides this because its assignment comes later.
                if (stale && !err_q) begin
                    err_q  <= 1'b1;
                    code_q <= 2'b11;
                end
                unique case (state)
                    IDLE: begin
                        if (dump_req) begin
                            idx    <= '0;
                            acnt   <= '0;
                            err_q  <= 1'b0;
                            code_q <= 2'b00;
                            busy_q <= 1'b1;
                            state  <= ALIGN;
                        end
                    end
                    ALIGN: begin
                        if (tag == '0) begin
                            state <= CAPTURE;
                        end else if (acnt == ACNT_MAX) begin
                            if (!err_q) begin
                                err_q  <= 1'b1;
                                code_q <= 2'b10;
                            end
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acnt <= acnt + 1'b1;
                        end
                    end
                    CAPTURE: begin
                        data_q <= dbgfifo_regs_data;
                        if (tag != idx) begin
                            if (!err_q) begin
                                err_q  <= 1'b1;
                                code_q <= 2'b01;
                            end
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            valid_q <= 1'b1;
                            state   <= PUSH;
                        end
                    end
                    PUSH: begin
                        if (dump_if.dump_ready) begin
                            valid_q <= 1'b0;
                            if (idx == LAST_IDX) begin
                                done_q <= 1'b1;
                                state  <= DONE;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= CAPTURE;
                            end
                        end
                    end
                    DONE: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign dump_busy          = busy_q;
    assign dump_done          = done_q;
    assign dump_err           = err_q;
    assign dump_err_code      = code_q;
    assign dump_if.dump_valid = valid_q;
    assign dump_if.dump_data  = data_q;

endmodule

// File: doc/pa_dtu_dbginfo_dump.md
# pa_dtu_dbginfo_dump

Debug-info dump sequencer in the DTU, directly downstream of the debug-info snapshot register block. On a dump request it aligns the snapshot read pointer to word 0 and reads all NUM_WORDS 32-bit words by pulsing the snapshot block's read strobe. It checks the 4-bit pointer tag in each word and streams the words to the debug-module side over a valid/ready interface, ending with the pointer wrapped back to 0.

## Interface
Parameters:
- NUM_WORDS, 11, number of snapshot words; the pointer wraps from NUM_WORDS-1 to 0.
- PTR_WIDTH, 4, width of the pointer tag in word bits [PTR_WIDTH-1:0].
- DATA_WIDTH, 32, word width.

Ports:
- dbginfo_clk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- dump_req  in  1  start-dump pulse; ignored unless IDLE.
- dump_abort  in  1  abort; highest priority.
- dbgfifo_regs_data  in  DATA_WIDTH  current snapshot word, combinational from the snapshot pointer; bits [3:0] are the pointer tag.
- dbg_info_record  in  1  snapshot capture pulse from the snapshot block.
- dump_rd_strobe  out  1  one-cycle read strobe; advances the snapshot pointer at the next edge.
- dump_busy  out  1  high in any state other than IDLE.
- dump_valid  out  1  output word valid.
- dump_data  out  DATA_WIDTH  output word (registered).
- dump_ready  in  1  consumer ready.
- dump_done  out  1  one-cycle completion pulse.
- dump_err  out  1  sticky error; cleared on the next accepted dump_req.
- dump_err_code  out  2  error code: 00 none, 01 tag mismatch, 10 align timeout, 11 stale snapshot.

## Operation
- States: IDLE, ALIGN, CAPTURE, PUSH, DONE. Internal word index idx is PTR_WIDTH bits wide. Internal align counter acnt is PTR_WIDTH+1 bits wide.
- IDLE: on dump_req, clear idx, acnt, dump_err and dump_err_code, then go to ALIGN.
- ALIGN:
  - If the tag is 0, go to CAPTURE.
  - Otherwise, if acnt == NUM_WORDS, set error 10 and go to DONE.
  - Otherwise, assert dump_rd_strobe, increment acnt and stay in ALIGN.
- CAPTURE:
  - Load dump_data from dbgfifo_regs_data.
  - If the tag != idx, set error 01, latch the word anyway, and go to DONE.
  - Otherwise go to PUSH.
- PUSH:
  - dump_valid=1. dump_data holds while dump_valid && !dump_ready.
  - On dump_valid && dump_ready, assert dump_rd_strobe in the same cycle.
  - If idx == NUM_WORDS-1, go to DONE. This final strobe wraps the pointer to 0.
  - Otherwise increment idx and go to CAPTURE.
- DONE: dump_done=1 for one cycle, then go to IDLE.
- Stale snapshot: dbg_info_record high in ALIGN, CAPTURE or PUSH sets error 11. The dump continues to completion. Error 11 overrides a previously latched code only if no error is set yet; the first error wins.
- dump_abort in any non-IDLE state: go to IDLE next cycle. No strobe in the abort cycle, no dump_done, dump_valid drops. Error state is kept.
- dump_req while busy: ignored.
- Simultaneous dump_req and dump_abort in IDLE: abort wins and the FSM stays in IDLE.
- Arithmetic: idx and acnt increments are unsigned and never exceed NUM_WORDS. The tag compare uses PTR_WIDTH bits.

## Timing
- Reset values: state IDLE; dump_data 0; dump_valid, dump_rd_strobe, dump_busy, dump_done, dump_err all 0; dump_err_code 00.
- dump_rd_strobe is a Moore-plus-handshake combinational output; the pointer updates at the following edge. dbgfifo_regs_data is sampled the cycle after the strobe with no extra settle cycle.
- Latency, aligned pointer and dump_ready tied high:
  - dump_req in cycle 0; ALIGN in cycle 1; CAPTURE in cycle 2; first dump_valid in cycle 3.
  - One word every 2 cycles (CAPTURE then PUSH).
  - dump_done in cycle 2+2*NUM_WORDS, which is cycle 24 for 11 words.
- Misaligned start with tag k: adds NUM_WORDS-k ALIGN strobe cycles.
- dump_valid, once asserted, stays high with stable data until accepted or aborted.
- Asynchronous reset mid-dump: all outputs return to reset values immediately. The snapshot pointer is not restored by this block.

## Test plan
- Aligned dump, ready=1: snapshot model with tag 0, words 0xA0..0xAA in bits [31:4] → 11 words with tags 0..10 in order; 11 strobes; dump_done at cycle 24; pointer ends at 0; dump_err=0.
- Misaligned start, pointer=7: → 4 ALIGN strobes (7→8→9→10→0), then a normal 11-word dump; total 15 strobes; no error.
- Backpressure: dump_ready low for 5 cycles on word 3 → dump_valid held high, dump_data stable, no strobe until accept; all words correct.
- Tag mismatch: the model skips word 5, returning tag 6 at idx 5 → dump_err=1, code 01, dump_done pulses, no further strobes.
- Stale and abort:
  - dbg_info_record pulsed at word 4 → dump completes, code 11.
  - Separate run: dump_abort during PUSH of word 2 → IDLE next cycle, no dump_done, no strobe in the abort cycle.
- Broken pointer: the model never reaches tag 0 (stuck at 3) → after 11 ALIGN strobes, code 10 and dump_done.
